// File: rtl/ula_sequencer_if.sv
// Command handshake and ULA drive/return lines of the ULA sequencer.
interface ula_sequencer_if;
  // command side
  logic       startSEQ;
  logic [3:0] opSEQ;
  logic [3:0] aInSEQ;
  logic [3:0] bInSEQ;
  logic       busySEQ;
  logic       doneSEQ;
  logic [3:0] resultSEQ;
  logic [3:0] remSEQ;
  logic       flagSEQ;
  // ULA side
  logic [3:0] aToULA;
  logic [3:0] bToULA;
  logic [2:0] selectToULA;
  logic [3:0] resultFromULA;
  logic       statusFromULA;

  // Requester: issues commands, owns the ULA, reads results.
  modport master (
    output startSEQ, opSEQ, aInSEQ, bInSEQ, resultFromULA, statusFromULA,
    input  busySEQ, doneSEQ, resultSEQ, remSEQ, flagSEQ,
           aToULA, bToULA, selectToULA
  );

  // Sequencer: accepts commands and drives the ULA.
  modport slave (
    input  startSEQ, opSEQ, aInSEQ, bInSEQ, resultFromULA, statusFromULA,
    output busySEQ, doneSEQ, resultSEQ, remSEQ, flagSEQ,
           aToULA, bToULA, selectToULA
  );
endinterface

// File: rtl/ula_sequencer.sv
// Multi-cycle controller sequencing a 4-bit ULA: single ops, MUL by repeated
// ADD, DIV by MENOR-compare / SUB loop, behind a start/busy/done handshake.
module ula_sequencer (
  input  logic           clk,
  input  logic           rst,
  ula_sequencer_if.slave bus
);

  localparam int unsigned DW  = 4;
  localparam int unsigned SW  = 3;

  localparam logic [SW-1:0] SEL_ADD   = 3'd0;
  localparam logic [SW-1:0] SEL_SUB   = 3'd1;
  localparam logic [SW-1:0] SEL_IGUAL = 3'd3;
  localparam logic [SW-1:0] SEL_MAIOR = 3'd4;
  localparam logic [SW-1:0] SEL_MENOR = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXEC,
    S_MUL_LOOP,
    S_DIV_CMP,
    S_DIV_SUB,
    S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] opa_q, opa_d;
  logic [DW-1:0] opb_q, opb_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [DW-1:0] rem_q, rem_d;
  logic [DW-1:0] quo_q, quo_d;
  logic [DW-1:0] result_q, result_d;
  logic [DW-1:0] remout_q, remout_d;
  logic          flag_q, flag_d;

  logic [DW-1:0] ula_a_c;
  logic [DW-1:0] ula_b_c;
  logic [SW-1:0] ula_sel_c;

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      opa_q    <= '0;
      opb_q    <= '0;
      sel_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      rem_q    <= '0;
      quo_q    <= '0;
      result_q <= '0;
      remout_q <= '0;
      flag_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      sel_q    <= sel_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      result_q <= result_d;
      remout_q <= remout_d;
      flag_q   <= flag_d;
    end
  end

  // Next-state, register updates and ULA drive for each state.
  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sel_d     = sel_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    result_d  = result_q;
    remout_d  = remout_q;
    flag_d    = flag_q;
    ula_a_c   = '0;
    ula_b_c   = '0;
    ula_sel_c = SEL_ADD;

    unique case (state_q)
      S_IDLE: begin
        if (bus.startSEQ) begin
          opa_d = bus.aInSEQ;
          opb_d = bus.bInSEQ;
          sel_d = bus.opSEQ[SW-1:0];
          if (!bus.opSEQ[3]) begin
            state_d = S_EXEC;
          end else if (bus.opSEQ == 4'd8) begin
            acc_d   = '0;
            cnt_d   = bus.bInSEQ;
            ovf_d   = 1'b0;
            state_d = S_MUL_LOOP;
          end else if (bus.opSEQ == 4'd9 && bus.bInSEQ != '0) begin
            rem_d   = bus.aInSEQ;
            quo_d   = '0;
            state_d = S_DIV_CMP;
          end else if (bus.opSEQ == 4'd9) begin
            // divide by zero: saturated quotient, dividend as remainder
            result_d = 4'hF;
            remout_d = bus.aInSEQ;
            flag_d   = 1'b1;
            state_d  = S_DONE;
          end else begin
            result_d = '0;
            remout_d = '0;
            flag_d   = 1'b1;
            state_d  = S_DONE;
          end
        end
      end

      S_EXEC: begin
        ula_sel_c = sel_q;
        ula_a_c   = opa_q;
        ula_b_c   = opb_q;
        // IGUAL leaves the ULA result stale, so report 0 instead
        result_d  = (sel_q == SEL_IGUAL) ? '0 : bus.resultFromULA;
        flag_d    = (sel_q == SEL_IGUAL || sel_q == SEL_MAIOR || sel_q == SEL_MENOR)
                    ? bus.statusFromULA : 1'b0;
        remout_d  = '0;
        state_d   = S_DONE;
      end

      S_MUL_LOOP: begin
        ula_sel_c = SEL_ADD;
        ula_a_c   = acc_q;
        ula_b_c   = opa_q;
        if (cnt_q != '0) begin
          acc_d = bus.resultFromULA;
          cnt_d = cnt_q - 4'd1;
          ovf_d = ovf_q | (({1'b0, acc_q} + {1'b0, opa_q}) > 5'd15);
        end else begin
          result_d = acc_q;
          flag_d   = ovf_q;
          remout_d = '0;
          state_d  = S_DONE;
        end
      end

      S_DIV_CMP: begin
        ula_sel_c = SEL_MENOR;
        ula_a_c   = rem_q;
        ula_b_c   = opb_q;
        if (bus.statusFromULA) begin
          result_d = quo_q;
          remout_d = rem_q;
          flag_d   = 1'b0;
          state_d  = S_DONE;
        end else begin
          state_d = S_DIV_SUB;
        end
      end

      S_DIV_SUB: begin
        ula_sel_c = SEL_SUB;
        ula_a_c   = rem_q;
        ula_b_c   = opb_q;
        rem_d     = bus.resultFromULA;
        quo_d     = quo_q + 4'd1;
        state_d   = S_DIV_CMP;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.busySEQ     = (state_q != S_IDLE);
  assign bus.doneSEQ     = (state_q == S_DONE);
  assign bus.resultSEQ   = result_q;
  assign bus.remSEQ      = remout_q;
  assign bus.flagSEQ     = flag_q;
  assign bus.aToULA      = ula_a_c;
  assign bus.bToULA      = ula_b_c;
  assign bus.selectToULA = ula_sel_c;

endmodule
